// File: rtl/xbar_dist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : xbar_dist_ctrl
//  Purpose  : Packet FIFO and replay sequencer that feeds the distribution
//             crossbar with data and per-PE select fields.
//  Revision : 1.0  initial release
// ============================================================================
module xbar_dist_ctrl #(
    parameter int DATA_TYPE  = 16,
    parameter int NUM_PES    = 4,
    parameter int INPUT_BW   = 4,
    parameter int LOG2_PES   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_W      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [INPUT_BW*DATA_TYPE-1:0]   i_data_bus,
    input  logic [1:0]                      i_mode,
    input  logic [LOG2_PES*NUM_PES-1:0]     i_sel,
    input  logic [REP_W-1:0]                i_rep,
    output logic [INPUT_BW*DATA_TYPE-1:0]   o_data_bus,
    output logic [LOG2_PES*NUM_PES-1:0]     o_mux_bus,
    output logic                            o_issue_valid,
    output logic                            o_dist_valid,
    output logic                            o_busy,
    output logic                            o_sel_err
);

    localparam int c_data_w  = INPUT_BW * DATA_TYPE;
    localparam int c_sel_w   = LOG2_PES * NUM_PES;
    localparam int c_entry_w = c_data_w + 2 + c_sel_w + REP_W;
    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w   = c_ptr_w + 1;

    localparam logic [1:0] c_mode_bcast = 2'd0;
    localparam logic [1:0] c_mode_ident = 2'd1;
    localparam logic [1:0] c_mode_rot   = 2'd2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // FIFO storage and pointers
    logic [c_entry_w-1:0] mem_q [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic                 push, pop;

    // FIFO head fields
    logic [c_entry_w-1:0] head;
    logic [c_data_w-1:0]  head_data;
    logic [1:0]           head_mode;
    logic [c_sel_w-1:0]   head_sel;
    logic [REP_W-1:0]     head_rep;

    // Sequencer state and hold registers for the packet being replayed
    state_t               state_q, state_d;
    logic [REP_W-1:0]     r_q, r_d;
    logic [REP_W-1:0]     rep_q, rep_d;
    logic [1:0]           mode_q, mode_d;
    logic [c_sel_w-1:0]   sel_q, sel_d;
    logic                 last;

    // Registered crossbar-facing outputs
    logic [c_data_w-1:0]  data_q, data_d;
    logic [c_sel_w-1:0]   mux_q, mux_d;
    logic                 dist_valid_q, dist_valid_d;
    logic                 sel_err_q, sel_err_d;

    assign head      = mem_q[rd_ptr_q];
    assign head_data = head[c_entry_w-1 -: c_data_w];
    assign head_mode = head[c_sel_w+REP_W +: 2];
    assign head_sel  = head[REP_W +: c_sel_w];
    assign head_rep  = head[0 +: REP_W];

    // Full is judged on the registered count, so a same-cycle pop never reopens o_ready
    assign o_ready = (count_q != c_cnt_w'(FIFO_DEPTH));
    assign push    = i_valid & o_ready;

    assign o_data_bus    = data_q;
    assign o_mux_bus     = mux_q;
    assign o_issue_valid = (state_q == ISSUE);
    assign o_dist_valid  = dist_valid_q;
    assign o_busy        = (count_q != '0) | (state_q == ISSUE);
    assign o_sel_err     = sel_err_q;

    // Packet storage write port; contents need no reset because count gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_data_bus, i_mode, i_sel, i_rep};
        end
    end

    // Next-state logic: pop the head when idle or on the last repeat of a packet
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        pop     = 1'b0;
        last    = (r_q == rep_q - REP_W'(1));
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                    r_d     = '0;
                end
            end
            ISSUE: begin
                if (last) begin
                    if (count_q != '0) begin
                        pop = 1'b1;
                        r_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    r_d = r_q + REP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;
        count_d  = count_q + c_cnt_w'(push) - c_cnt_w'(pop);
    end

    // Select generation for the issue that becomes visible after this edge
    always_comb begin
        logic [LOG2_PES-1:0] sel_p;
        logic [LOG2_PES-1:0] fld;
        sel_p        = '0;
        fld          = '0;
        mode_d       = pop ? head_mode : mode_q;
        sel_d        = pop ? head_sel  : sel_q;
        rep_d        = pop ? ((head_rep == '0) ? REP_W'(1) : head_rep) : rep_q;
        data_d       = pop ? head_data : data_q;
        mux_d        = mux_q;
        sel_err_d    = sel_err_q;
        dist_valid_d = (state_q == ISSUE);
        if (state_d == ISSUE) begin
            for (int p = 0; p < NUM_PES; p++) begin
                sel_p = sel_d[p*LOG2_PES +: LOG2_PES];
                case (mode_d)
                    c_mode_bcast: fld = '0;
                    c_mode_ident: fld = LOG2_PES'(p % INPUT_BW);
                    // Wide integer arithmetic keeps p+r from wrapping before the mod
                    c_mode_rot:   fld = LOG2_PES'((p + int'(r_d)) % INPUT_BW);
                    default: begin
                        if (int'(sel_p) >= INPUT_BW) begin
                            fld       = '0;
                            sel_err_d = 1'b1;
                        end else begin
                            fld = sel_p;
                        end
                    end
                endcase
                mux_d[p*LOG2_PES +: LOG2_PES] = fld;
            end
        end
    end

    // State, pointer, hold and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            r_q          <= '0;
            rep_q        <= '0;
            mode_q       <= '0;
            sel_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_q       <= '0;
            mux_q        <= '0;
            dist_valid_q <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            rep_q        <= rep_d;
            mode_q       <= mode_d;
            sel_q        <= sel_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_q       <= data_d;
            mux_q        <= mux_d;
            dist_valid_q <= dist_valid_d;
            sel_err_q    <= sel_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xbar_dist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xbar_dist_ctrl
//  Purpose  : Directed self-checking bench for xbar_dist_ctrl
//  Revision : 1.0  initial release
// ============================================================================
module tb_xbar_dist_ctrl;

    localparam int DW = 16;
    localparam int NP = 4;
    localparam int IBW = 4;
    localparam int LP = 3;
    localparam int FD = 4;
    localparam int RW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid;
    logic              o_ready;
    logic [IBW*DW-1:0] i_data_bus;
    logic [1:0]        i_mode;
    logic [LP*NP-1:0]  i_sel;
    logic [RW-1:0]     i_rep;
    logic [IBW*DW-1:0] o_data_bus;
    logic [LP*NP-1:0]  o_mux_bus;
    logic              o_issue_valid;
    logic              o_dist_valid;
    logic              o_busy;
    logic              o_sel_err;

    int n_vec = 0;
    int n_err = 0;

    xbar_dist_ctrl #(
        .DATA_TYPE (DW),
        .NUM_PES   (NP),
        .INPUT_BW  (IBW),
        .LOG2_PES  (LP),
        .FIFO_DEPTH(FD),
        .REP_W     (RW)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data_bus   (i_data_bus),
        .i_mode       (i_mode),
        .i_sel        (i_sel),
        .i_rep        (i_rep),
        .o_data_bus   (o_data_bus),
        .o_mux_bus    (o_mux_bus),
        .o_issue_valid(o_issue_valid),
        .o_dist_valid (o_dist_valid),
        .o_busy       (o_busy),
        .o_sel_err    (o_sel_err)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pack four PE select values, PE3 in the most significant field
    function automatic logic [LP*NP-1:0] mux4(input int a3, input int a2, input int a1, input int a0);
        return {LP'(a3), LP'(a2), LP'(a1), LP'(a0)};
    endfunction

    // Distinct packet payload: element i of packet k is k*16+i
    function automatic logic [IBW*DW-1:0] pkt(input int k);
        logic [IBW*DW-1:0] v;
        v = '0;
        for (int i = 0; i < IBW; i++) v[i*DW +: DW] = DW'(k*16 + i);
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b0; i_valid = 1'b1; i_data_bus = pkt(7); i_mode = 2'd1; i_sel = '0; i_rep = 4'd1;
        repeat (3) tick();
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        n_vec++; if (o_data_bus !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", o_data_bus); end
        n_vec++; if (o_mux_bus !== '0) begin n_err++; $display("FAIL reset_mux: got %h want 0", o_mux_bus); end
        n_vec++; if ({o_issue_valid, o_dist_valid, o_busy, o_sel_err} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b want 0000", {o_issue_valid, o_dist_valid, o_busy, o_sel_err}); end
        i_valid = 1'b0;
        rst = 1'b1;
        tick();
        n_vec++; if ({o_busy, o_issue_valid} !== 2'b00) begin
            n_err++; $display("FAIL reset_release_busy: got %b want 00", {o_busy, o_issue_valid}); end
    endtask

    task automatic test_identity();
        logic [IBW*DW-1:0] d;
        d = {16'd4, 16'd3, 16'd2, 16'd1};
        i_data_bus = d; i_mode = 2'd1; i_rep = 4'd1; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        n_vec++; if ({o_issue_valid, o_busy} !== 2'b01) begin
            n_err++; $display("FAIL ident_after_push: got %b want 01", {o_issue_valid, o_busy}); end
        tick();
        n_vec++; if ({o_issue_valid, o_dist_valid} !== 2'b10) begin
            n_err++; $display("FAIL ident_issue_flags: got %b want 10", {o_issue_valid, o_dist_valid}); end
        n_vec++; if (o_data_bus !== d) begin n_err++; $display("FAIL ident_data: got %h want %h", o_data_bus, d); end
        n_vec++; if (o_mux_bus !== mux4(3, 2, 1, 0)) begin
            n_err++; $display("FAIL ident_mux: got %h want %h", o_mux_bus, mux4(3, 2, 1, 0)); end
        tick();
        n_vec++; if ({o_issue_valid, o_dist_valid} !== 2'b01) begin
            n_err++; $display("FAIL ident_dist: got %b want 01", {o_issue_valid, o_dist_valid}); end
        n_vec++; if (o_data_bus !== d) begin n_err++; $display("FAIL ident_hold: got %h want %h", o_data_bus, d); end
        tick();
        n_vec++; if ({o_dist_valid, o_busy} !== 2'b00) begin
            n_err++; $display("FAIL ident_idle: got %b want 00", {o_dist_valid, o_busy}); end
        // Broadcast with rep=0 issues exactly once
        i_data_bus = pkt(3); i_mode = 2'd0; i_rep = 4'd0; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        n_vec++; if (o_issue_valid !== 1'b1 || o_mux_bus !== '0) begin
            n_err++; $display("FAIL bcast_issue: got v=%b mux=%h want v=1 mux=0", o_issue_valid, o_mux_bus); end
        tick();
        n_vec++; if ({o_issue_valid, o_dist_valid} !== 2'b01) begin
            n_err++; $display("FAIL bcast_rep0_once: got %b want 01", {o_issue_valid, o_dist_valid}); end
    endtask

    task automatic test_rotate();
        logic [LP*NP-1:0] exp_mux [3];
        int issues;
        exp_mux[0] = mux4(3, 2, 1, 0);
        exp_mux[1] = mux4(0, 3, 2, 1);
        exp_mux[2] = mux4(1, 0, 3, 2);
        issues = 0;
        i_data_bus = pkt(5); i_mode = 2'd2; i_rep = 4'd3; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int r = 0; r < 3; r++) begin
            tick();
            if (o_issue_valid === 1'b1) issues++;
            n_vec++; if (o_mux_bus !== exp_mux[r]) begin
                n_err++; $display("FAIL rotate_mux_r%0d: got %h want %h", r, o_mux_bus, exp_mux[r]); end
        end
        tick();
        if (o_issue_valid === 1'b1) issues++;
        n_vec++; if (issues != 3) begin n_err++; $display("FAIL rotate_issue_count: got %0d want 3", issues); end
        n_vec++; if (o_mux_bus !== exp_mux[2] || o_dist_valid !== 1'b1) begin
            n_err++; $display("FAIL rotate_hold: got mux=%h dv=%b want mux=%h dv=1", o_mux_bus, o_dist_valid, exp_mux[2]); end
        tick();
    endtask

    task automatic test_back_to_back();
        // Five rep=2 packets pushed on consecutive edges; issues run edges 2..11 with no gap
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc <= 5) begin
                i_valid = 1'b1; i_data_bus = pkt(cyc + 19); i_mode = 2'd1; i_rep = 4'd2;
                n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_%0d: got %b want 1", cyc, o_ready); end
            end else begin
                i_valid = 1'b0;
            end
            tick();
            if (cyc >= 2 && cyc <= 11) begin
                n_vec++; if (o_issue_valid !== 1'b1 || o_data_bus !== pkt((cyc - 2) / 2 + 20)) begin
                    n_err++; $display("FAIL b2b_issue_%0d: got v=%b d=%h want v=1 d=%h",
                                      cyc, o_issue_valid, o_data_bus, pkt((cyc - 2) / 2 + 20)); end
            end else begin
                n_vec++; if (o_issue_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle_%0d: got %b want 0", cyc, o_issue_valid); end
            end
        end
    endtask

    task automatic test_full();
        // Long first packet lets four more fill the FIFO; ready stays low through the pop cycle
        for (int cyc = 1; cyc <= 21; cyc++) begin
            if (cyc <= 5) begin
                i_valid = 1'b1; i_data_bus = pkt(cyc + 39); i_mode = 2'd1;
                i_rep = (cyc == 1) ? 4'd15 : 4'd1;
            end else begin
                i_valid = 1'b0;
            end
            tick();
            if (cyc >= 5) begin
                n_vec++; if (o_ready !== ((cyc >= 17) ? 1'b1 : 1'b0)) begin
                    n_err++; $display("FAIL full_ready_%0d: got %b want %b", cyc, o_ready, (cyc >= 17)); end
            end
            if (cyc >= 2 && cyc <= 20) begin
                n_vec++; if (o_issue_valid !== 1'b1 || o_data_bus !== pkt((cyc <= 16) ? 40 : cyc + 24)) begin
                    n_err++; $display("FAIL full_issue_%0d: got v=%b d=%h want v=1 d=%h",
                                      cyc, o_issue_valid, o_data_bus, pkt((cyc <= 16) ? 40 : cyc + 24)); end
            end
        end
        n_vec++; if ({o_issue_valid, o_busy} !== 2'b00) begin
            n_err++; $display("FAIL full_drained: got %b want 00", {o_issue_valid, o_busy}); end
    endtask

    task automatic test_explicit();
        i_data_bus = pkt(60); i_mode = 2'd3; i_rep = 4'd1;
        i_sel = {3'd2, 3'd5, 3'd1, 3'd3};
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        n_vec++; if (o_sel_err !== 1'b0) begin n_err++; $display("FAIL expl_err_early: got %b want 0", o_sel_err); end
        tick();
        n_vec++; if (o_mux_bus !== mux4(2, 0, 1, 3)) begin
            n_err++; $display("FAIL expl_mux: got %h want %h", o_mux_bus, mux4(2, 0, 1, 3)); end
        n_vec++; if (o_sel_err !== 1'b1) begin n_err++; $display("FAIL expl_err_set: got %b want 1", o_sel_err); end
        // Push lands on the last repeat with an empty FIFO: one idle cycle before it issues
        i_data_bus = pkt(61); i_mode = 2'd1; i_sel = '0; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        n_vec++; if ({o_issue_valid, o_busy} !== 2'b01) begin
            n_err++; $display("FAIL expl_idle_gap: got %b want 01", {o_issue_valid, o_busy}); end
        tick();
        n_vec++; if (o_issue_valid !== 1'b1 || o_mux_bus !== mux4(3, 2, 1, 0) || o_sel_err !== 1'b1) begin
            n_err++; $display("FAIL expl_sticky: got v=%b mux=%h err=%b want v=1 mux=%h err=1",
                              o_issue_valid, o_mux_bus, o_sel_err, mux4(3, 2, 1, 0)); end
        tick();
    endtask

    task automatic test_reset_mid_issue();
        i_data_bus = pkt(70); i_mode = 2'd2; i_rep = 4'd3; i_valid = 1'b1;
        tick();
        i_data_bus = pkt(71);
        tick();
        i_valid = 1'b0;
        tick();
        n_vec++; if (o_issue_valid !== 1'b1 || o_mux_bus !== mux4(0, 3, 2, 1)) begin
            n_err++; $display("FAIL mid_pre_reset: got v=%b mux=%h want v=1 mux=%h", o_issue_valid, o_mux_bus, mux4(0, 3, 2, 1)); end
        rst = 1'b0;
        #1;
        n_vec++; if (o_ready !== 1'b1 || o_data_bus !== '0 || o_mux_bus !== '0 ||
                     {o_issue_valid, o_dist_valid, o_busy, o_sel_err} !== 4'b0000) begin
            n_err++; $display("FAIL mid_reset_outputs: got rdy=%b d=%h mux=%h flags=%b want rdy=1 rest 0",
                              o_ready, o_data_bus, o_mux_bus, {o_issue_valid, o_dist_valid, o_busy, o_sel_err}); end
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if ({o_issue_valid, o_dist_valid, o_busy} !== 3'b000) begin
                n_err++; $display("FAIL mid_post_reset_%0d: got %b want 000", k, {o_issue_valid, o_dist_valid, o_busy}); end
        end
    endtask

    initial begin
        rst = 1'b0; i_valid = 1'b0; i_data_bus = '0; i_mode = '0; i_sel = '0; i_rep = '0;
        test_reset();
        test_identity();
        test_rotate();
        test_back_to_back();
        test_full();
        test_explicit();
        test_reset_mid_issue();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
